onehot_decoder: RTL

//   Registered N-to-2^N one-hot decoder with valid/ready handshake on both sides.

---
 rtl/onehot_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes on both sides.
// A two-entry (main + skid) buffer keeps full throughput while o_ready is driven only from state.
module onehot_decoder #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [IN_WIDTH-1:0]  i_code,
    input  logic                 i_enable,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_onehot,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_range_err,
    input  logic                 i_err_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   main_q, main_d;
    logic [OUT_WIDTH-1:0]   skid_q, skid_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   fire;
    logic                   range_violation;
    logic [OUT_WIDTH-1:0]   decoded;

    // Codes at or above OUT_WIDTH, and any code with enable low, decode to all zeros.
    function automatic logic [OUT_WIDTH-1:0] decode(input logic [IN_WIDTH-1:0] code,
                                                    input logic                en);
        logic [OUT_WIDTH-1:0] word;
        word = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (en && (int'(code) == i)) begin
                word[i] = 1'b1;
            end
        end
        return word;
    endfunction

    assign decoded         = decode(i_code, i_enable);
    assign range_violation = i_enable && (int'(i_code) >= OUT_WIDTH);

    assign o_valid  = (state_q != ST_EMPTY);
    assign o_ready  = (state_q != ST_SKID);
    assign o_onehot = main_q;
    assign o_range_err = err_q;

    assign accept = i_valid & o_ready;
    assign fire   = o_valid & i_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = decoded;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && fire) begin
                    main_d = decoded;
                end else if (accept) begin
                    skid_d  = decoded;
                    state_d = ST_SKID;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (fire) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // A new violation takes priority over a clear arriving in the same cycle.
    always_comb begin
        err_d = err_q;
        if (accept && range_violation) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: state uses non-blocking assignments so all registers update together at the edge.
        if (!i_reset_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

endmodule
